// File: rtl/ifetch_line_buffer.sv
// Single-line instruction buffer between the fetch stage and the slow
// instruction memory. It serves words combinationally on a hit and issues
// one start/ready line read on a miss.
module ifetch_line_buffer #(
  parameter int unsigned DATA_SIZE_BYTES = 16,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_req,
  input  logic [ADDR_WIDTH-1:0]        fetch_pc,
  input  logic                         invalidate,
  output logic [31:0]                  instr_out,
  output logic                         instr_valid,
  output logic                         busy,
  output logic [31:0]                  miss_count,
  output logic [ADDR_WIDTH-1:0]        imemory_address,
  output logic                         imem_read_start,
  input  logic                         imem_read_rdy,
  input  logic [8*DATA_SIZE_BYTES-1:0] imemory_data
);

  localparam int unsigned OFF    = $clog2(DATA_SIZE_BYTES);
  localparam int unsigned TAG_W  = ADDR_WIDTH - OFF;
  localparam int unsigned IDX_W  = OFF - 2;
  localparam int unsigned LINE_W = 8 * DATA_SIZE_BYTES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   line_data_q, line_data_d;
  logic [TAG_W-1:0]    line_tag_q, line_tag_d;
  logic                line_valid_q, line_valid_d;
  logic                drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]         miss_count_q, miss_count_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;

  logic [TAG_W-1:0]    pc_tag;
  logic [IDX_W-1:0]    word_idx;
  logic                hit;
  logic                unused_pc_bits;

  // Address decode and combinational hit/serve path.
  always_comb begin
    pc_tag      = fetch_pc[ADDR_WIDTH-1:OFF];
    word_idx    = fetch_pc[OFF-1:2];
    hit         = line_valid_q && (line_tag_q == pc_tag);
    instr_valid = fetch_req && hit && !busy_q;
    instr_out   = line_data_q[{word_idx, 5'b0} +: 32];
  end

  // Byte-offset bits within a word are deliberately ignored.
  assign unused_pc_bits = ^fetch_pc[1:0];

  // Next-state logic for the read FSM and the held line.
  always_comb begin
    state_d      = state_q;
    line_data_d  = line_data_q;
    line_tag_d   = line_tag_q;
    line_valid_d = line_valid_q;
    drop_d       = drop_q;
    addr_d       = addr_q;
    miss_count_d = miss_count_q;

    case (state_q)
      S_IDLE: begin
        if (invalidate) begin
          line_valid_d = 1'b0;
        end
        if (fetch_req && !hit && !invalidate) begin
          state_d = S_REQ;
          addr_d  = {pc_tag, {OFF{1'b0}}};
        end
      end
      S_REQ: begin
        state_d      = S_WAIT;
        miss_count_d = miss_count_q + 32'd1;
        if (invalidate) begin
          drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (invalidate) begin
          drop_d = 1'b1;
        end
        if (imem_read_rdy) begin
          // An invalidate in the return cycle also discards the fill.
          if (!drop_q && !invalidate) begin
            line_data_d  = imemory_data;
            line_tag_d   = addr_q[ADDR_WIDTH-1:OFF];
            line_valid_d = 1'b1;
          end
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    start_d = (state_d == S_REQ);
    busy_d  = (state_d != S_IDLE);
  end

  // State and line registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      line_data_q  <= '0;
      line_tag_q   <= '0;
      line_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      addr_q       <= '0;
      miss_count_q <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_data_q  <= line_data_d;
      line_tag_q   <= line_tag_d;
      line_valid_q <= line_valid_d;
      drop_q       <= drop_d;
      addr_q       <= addr_d;
      miss_count_q <= miss_count_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
    end
  end

  assign imemory_address = addr_q;
  assign imem_read_start = start_q;
  assign busy            = busy_q;
  assign miss_count      = miss_count_q;

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Scoreboard bench for ifetch_line_buffer: the driver predicts start pulses
// and served words from a line-level model; a monitor compares on negedges.
module tb_ifetch_line_buffer;

  localparam int unsigned DSB = 16;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 8 * DSB;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_pc;
  logic          invalidate;
  logic [31:0]   instr_out;
  logic          instr_valid;
  logic          busy;
  logic [31:0]   miss_count;
  logic [AW-1:0] imemory_address;
  logic          imem_read_start;
  logic          imem_read_rdy;
  logic [LW-1:0] imemory_data;

  ifetch_line_buffer #(.DATA_SIZE_BYTES(DSB), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .fetch_pc        (fetch_pc),
    .invalidate      (invalidate),
    .instr_out       (instr_out),
    .instr_valid     (instr_valid),
    .busy            (busy),
    .miss_count      (miss_count),
    .imemory_address (imemory_address),
    .imem_read_start (imem_read_start),
    .imem_read_rdy   (imem_read_rdy),
    .imemory_data    (imemory_data)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned cyc; logic [31:0] addr; } start_exp_t;
  typedef struct { int unsigned cyc; logic [31:0] instr; logic [31:0] count; } serve_exp_t;

  start_exp_t  sq[$];
  serve_exp_t  vq[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          served = 0;

  // Line-level model: which line is held, and whether a read is outstanding.
  bit          m_valid;
  logic [27:0] m_line;
  bit          m_out;
  bit          m_start_due;
  logic [27:0] m_out_line;
  bit          m_drop;
  logic [31:0] m_count;
  bit          exp_busy;
  logic [31:0] exp_addr;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: line 0 is the fixed pattern, others a hash of address.
  function automatic logic [31:0] word_at(input logic [27:0] line, input int unsigned i);
    if (line == 28'd0) return 32'h1111_1111 * 32'(i + 1);
    return (32'(line) * 32'h9E37_79B1) ^ (32'(i) * 32'h0100_0193) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [27:0] line);
    logic [LW-1:0] d;
    for (int i = 0; i < int'(DSB / 4); i++) d[32*i +: 32] = word_at(line, i);
    return d;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid && (m_line == pc[31:4]);
  endfunction

  // One clock of stimulus: predict, push expectations, advance the model.
  task automatic step(input bit req, input logic [31:0] pc, input bit inv, input bit rdy);
    fetch_req     = req;
    fetch_pc      = pc;
    invalidate    = inv;
    imem_read_rdy = rdy;
    imemory_data  = (rdy && m_out) ? line_of(m_out_line)
                                   : {$urandom, $urandom, $urandom, $urandom};
    exp_busy = m_out;
    exp_addr = {m_out_line, 4'b0};
    if (m_start_due) sq.push_back('{cyc, {m_out_line, 4'b0}});
    if (req && !m_out && model_hit(pc))
      vq.push_back('{cyc, word_at(pc[31:4], int'(pc[3:2])), m_count});
    @(posedge clk);
    if (!m_out) begin
      if (req && !model_hit(pc) && !inv) begin
        m_out       = 1'b1;
        m_start_due = 1'b1;
        m_out_line  = pc[31:4];
        m_count     = m_count + 32'd1;
      end else if (inv) begin
        m_valid = 1'b0;
      end
    end else if (m_start_due) begin
      m_start_due = 1'b0;
      m_drop      = m_drop | inv;
    end else if (rdy) begin
      if (!(m_drop || inv)) begin
        m_valid = 1'b1;
        m_line  = m_out_line;
      end
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else begin
      m_drop = m_drop | inv;
    end
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must drop to reset values at once.
  task automatic do_reset();
    reset         = 1'b0;
    fetch_req     = 1'b0;
    fetch_pc      = '0;
    invalidate    = 1'b0;
    imem_read_rdy = 1'b0;
    imemory_data  = '0;
    m_valid = 0; m_line = '0; m_out = 0; m_start_due = 0;
    m_out_line = '0; m_drop = 0; m_count = '0;
    exp_busy = 1'b0;
    exp_addr = '0;
    sq.delete();
    vq.delete();
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_start", 32'(imem_read_start), 32'd0);
    check("rst_count", miss_count, 32'd0);
    check("rst_addr", imemory_address, 32'd0);
    check("rst_instr", instr_out, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: pops expectations when the DUT presents a start or a word.
  initial begin
    start_exp_t se;
    serve_exp_t ve;
    forever begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(exp_busy));
      if (exp_busy) check("out_addr", imemory_address, exp_addr);
      if (imem_read_start === 1'b1) begin
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start got=1 want=0 cyc=%0d", cyc);
        end else begin
          se = sq.pop_front();
          check("start_addr", imemory_address, se.addr);
          check("start_cyc", cyc, se.cyc);
        end
      end else if (sq.size() != 0 && sq[0].cyc == cyc) begin
        total++; bad++;
        $display("FAIL missing_start got=0 want=1 cyc=%0d", cyc);
        void'(sq.pop_front());
      end
      if (instr_valid === 1'b1) begin
        if (vq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid got=1 want=0 pc=%h cyc=%0d", fetch_pc, cyc);
        end else begin
          ve = vq.pop_front();
          served++;
          check("instr", instr_out, ve.instr);
          check("miss_count", miss_count, ve.count);
          check("valid_cyc", cyc, ve.cyc);
        end
      end else if (vq.size() != 0 && vq[0].cyc == cyc) begin
        total++; bad++;
        $display("FAIL missing_valid got=0 want=1 cyc=%0d", cyc);
        void'(vq.pop_front());
      end
    end
  end

  logic [27:0] lines [4] = '{28'h0, 28'h1, 28'h2, 28'hABCDEF0};

  initial begin
    bit          req, inv, rdy;
    logic [31:0] pc;

    do_reset();

    // Cold fetch at 0x8: start next cycle, data after 5 cycles, then serve.
    repeat (5) step(1, 32'h8, 0, 0);
    step(1, 32'h8, 0, 1);
    step(1, 32'h8, 0, 0);
    check("cold_count", miss_count, 32'd1);

    // Same-line hits.
    step(1, 32'h0, 0, 0);
    step(1, 32'h4, 0, 0);
    step(1, 32'hC, 0, 0);

    // Line change.
    repeat (5) step(1, 32'h10, 0, 0);
    step(1, 32'h10, 0, 1);
    step(1, 32'h10, 0, 0);
    check("line_change_count", miss_count, 32'd2);

    // Invalidate two cycles after the start pulse.
    step(1, 32'h20, 0, 0);
    step(1, 32'h20, 0, 0);
    step(1, 32'h20, 0, 0);
    step(1, 32'h20, 1, 0);
    step(1, 32'h20, 0, 0);
    step(1, 32'h20, 0, 1);
    step(1, 32'h20, 0, 0);
    step(1, 32'h20, 0, 0);
    step(1, 32'h20, 0, 1);
    step(1, 32'h24, 0, 0);
    check("inv_count", miss_count, 32'd4);

    // Reset mid-WAIT, then a stray ready.
    repeat (3) step(1, 32'h30, 0, 0);
    do_reset();
    step(0, 32'h30, 0, 1);
    step(1, 32'h30, 0, 0);
    step(1, 32'h30, 0, 0);
    step(1, 32'h30, 0, 0);
    step(1, 32'h30, 0, 1);
    step(1, 32'h34, 0, 0);

    // Redirect during WAIT.
    step(1, 32'h40, 0, 0);
    step(1, 32'h40, 0, 0);
    step(1, 32'h50, 0, 0);
    step(1, 32'h50, 0, 0);
    step(1, 32'h50, 0, 1);
    step(1, 32'h50, 0, 0);
    step(1, 32'h50, 0, 0);
    step(1, 32'h50, 0, 1);
    step(1, 32'h58, 0, 0);

    // Randomized traffic over a few lines.
    for (int n = 0; n < 3000; n++) begin
      req = ($urandom_range(0, 9) < 8);
      pc  = {lines[$urandom_range(0, 3)], 4'($urandom)};
      inv = ($urandom_range(0, 19) == 0);
      if (m_out && !m_start_due) rdy = ($urandom_range(0, 2) == 0);
      else                       rdy = !m_out && ($urandom_range(0, 19) == 0);
      step(req, pc, inv, rdy);
    end

    // Drain any outstanding read.
    for (int n = 0; n < 20; n++) step(0, 32'h0, 0, m_out && !m_start_due);
    step(0, 32'h0, 0, 0);

    check("start_queue_left", 32'(sq.size()), 32'd0);
    check("serve_queue_left", 32'(vq.size()), 32'd0);
    total++;
    if (served < 20) begin
      bad++;
      $display("FAIL served_words got=%0d want>=20", served);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_line_buffer.md
# ifetch_line_buffer

CPU-side initiator for the slow instruction memory's start/ready line-read handshake. It holds one instruction line (DATA_SIZE_BYTES wide, default 128 bits) and serves 32-bit instructions to the fetch stage combinationally on a hit. On a miss it issues a single line read, fills the line and then resumes serving. It sits inside CPU, between the fetch stage and the instruction-memory ports of SYSTEM.

## Interface

Parameters:
- DATA_SIZE_BYTES, 16: line size in bytes. Power of two, at least 8. Must match the slow memory's DATA_SIZE_BYTES.
- ADDR_WIDTH, 32: byte-address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  input  1  fetch stage requests the instruction at fetch_pc.
- fetch_pc  input  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- invalidate  input  1  one-cycle pulse; discards the held line.
- instr_out  output  32  instruction word selected from the line.
- instr_valid  output  1  instr_out is valid for fetch_pc this cycle.
- busy  output  1  a line read is outstanding.
- miss_count  output  32  number of line reads issued; wraps modulo 2^32.
- imemory_address  output  ADDR_WIDTH  line-aligned read address.
- imem_read_start  output  1  one-cycle read-start pulse.
- imem_read_rdy  input  1  one-cycle pulse; imemory_data is valid in that cycle.
- imemory_data  input  8*DATA_SIZE_BYTES  returned line.

## Operation

Terms:
- OFF = log2(DATA_SIZE_BYTES).
- tag = fetch_pc[ADDR_WIDTH-1:OFF].
- word index = fetch_pc[OFF-1:2].
- Word i of the line is imemory_data[32*i+31 : 32*i].

State held: line_data, line_tag, line_valid, drop flag, FSM state (IDLE, REQ, WAIT).

Hit and output rules:
- Hit = line_valid and line_tag == tag. This is combinational.
- instr_valid = fetch_req and hit and not busy.
- instr_out = word [word index] of line_data, regardless of instr_valid.

FSM:
- IDLE → REQ when fetch_req is high, the request misses and invalidate is low. On that edge, latch imemory_address = {tag, OFF zeros}.
- REQ: imem_read_start = 1 for exactly this cycle. Unconditionally go to WAIT. Increment miss_count.
- WAIT: hold imemory_address stable. When imem_read_rdy = 1:
  - if drop is clear, write line_data = imemory_data, line_tag = the latched address tag, line_valid = 1;
  - if drop is set, leave line_valid = 0;
  - clear drop and go to IDLE.
- busy = 1 in REQ and WAIT.

Invalidate:
- In IDLE: clears line_valid at the edge.
- In REQ or WAIT: sets drop, so the in-flight fill is discarded.
- invalidate and imem_read_rdy in the same cycle: the fill is discarded.

Other rules:
- A fetch_pc change during REQ or WAIT has no effect on the outstanding read. After return to IDLE the new pc is evaluated normally and may miss again.
- imem_read_rdy while in IDLE is ignored, e.g. a stale response after reset.
- fetch_req low in IDLE issues no read. There is no prefetch.

Reset values (asserted asynchronously):
- state = IDLE; line_valid = 0; line_data = 0; line_tag = 0; drop = 0.
- imemory_address = 0; imem_read_start = 0; miss_count = 0.
- Consequently instr_valid = 0, busy = 0, instr_out = 0.
- Reset during REQ or WAIT abandons the read with no fill.

## Timing

- Hit: zero-cycle latency; instr_valid and instr_out are combinational in the request cycle.
- Miss with the request at cycle t:
  - REQ in t+1, start pulse in t+1.
  - WAIT from t+2.
  - With imem_read_rdy at cycle r ≥ t+2, the line is written at the end of r, and instr_valid rises at r+1 if fetch_req is held and the pc is in the same line.
- Back-to-back misses: at least 2 cycles between start pulses (IDLE, then REQ).
- imem_read_start is never high for two consecutive cycles and never high while busy was already set in the previous cycle.

## Test plan

- Reset and cold fetch: reset low for 2 cycles, then fetch_req = 1 with pc = 0x0000_0008. Required:
  - start pulse one cycle later with address 0x0000_0000;
  - memory returns 0x44444444_33333333_22222222_11111111 after 5 cycles;
  - next cycle instr_valid = 1 with instr_out = 0x33333333;
  - miss_count = 1.
- Same-line hits: after the fill, step pc through 0x0, 0x4, 0xC. Required: instr_out is 0x11111111, 0x22222222, 0x44444444 in consecutive cycles, with no start pulse.
- Line change: pc = 0x0000_0010 after the fill. Required: miss, address 0x0000_0010, busy = 1 until rdy, miss_count = 2, old line not served during busy.
- Invalidate during WAIT: pulse invalidate two cycles after start. Required: the fill is discarded, the FSM returns to IDLE, and a new start is issued for the same address, with miss_count incremented again.
- Reset mid-WAIT: assert reset while busy, then deliver imem_read_rdy after release. Required:
  - busy = 0 immediately;
  - stray rdy ignored and line_valid stays 0;
  - the next request misses.
- Redirect during WAIT: change fetch_pc to another line while waiting. Required:
  - the outstanding address is unchanged;
  - after the fill, the new pc misses and issues a second read one cycle after the return to IDLE.
